// File: rtl/binary_game_pkg.sv
// Shared constants for the binary matching game: state encodings, LFSR seed and
// maximal-length tap masks for widths 2..16.
package binary_game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_OVER = 2'b10
   } game_state_t;

   localparam int unsigned TIME_W    = 6;
   localparam logic [15:0] LFSR_SEED = 16'h0001;

   // Fibonacci tap mask (bit k-1 set for polynomial term x^k), maximal length per width
   function automatic logic [15:0] lfsr_taps(input int unsigned width);
      logic [15:0] taps;
      case (width)
         2:       taps = 16'h0003;
         3:       taps = 16'h0006;
         4:       taps = 16'h000C;
         5:       taps = 16'h0014;
         6:       taps = 16'h0030;
         7:       taps = 16'h0060;
         8:       taps = 16'h00B8;
         9:       taps = 16'h0110;
         10:      taps = 16'h0240;
         11:      taps = 16'h0500;
         12:      taps = 16'h0829;
         13:      taps = 16'h100D;
         14:      taps = 16'h2015;
         15:      taps = 16'h6000;
         default: taps = 16'hD008;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running maximal-length Fibonacci LFSR; nonzero seed keeps it out of the
// all-zero lock-up state.
module lfsr_gen
   import binary_game_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
   localparam logic [WIDTH-1:0] SEED = WIDTH'(LFSR_SEED);

   always_ff @(posedge clk) begin
      if (rst) value <= SEED;
      else     value <= {value[WIDTH-2:0], ^(value & TAPS)};
   end

endmodule

// File: rtl/binary_game_core.sv
// Binary matching game: player sets switches to a random target before the round
// timer expires; tracks score per game and the best score since reset.
module binary_game_core
   import binary_game_pkg::*;
#(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned GAME_SECONDS  = 30,
   parameter int unsigned TICKS_PER_SEC = 100000000,
   parameter int unsigned SUBMIT_MODE   = 0,
   parameter int unsigned MATCH_HOLD    = 4,
   parameter int unsigned PENALTY_SEC   = 2,
   parameter int unsigned SCORE_W       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   sw,
   input  logic               submit,
   output logic [WIDTH-1:0]   target,
   output logic [TIME_W-1:0]  time_left,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic [1:0]         state,
   output logic               hit
);

   localparam int unsigned TICK_W = $clog2(TICKS_PER_SEC);
   localparam int unsigned HOLD_W = (MATCH_HOLD > 1) ? $clog2(MATCH_HOLD) : 1;
   localparam int unsigned DEC_W  = TIME_W + 1;

   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MATCH_HOLD - 1);
   localparam logic [TIME_W-1:0]  GAME_TIME = TIME_W'(GAME_SECONDS);
   localparam logic [DEC_W-1:0]   PEN_TIME  = DEC_W'(PENALTY_SEC);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   game_state_t        st;
   logic               start_q;
   logic               submit_q;
   logic [TICK_W-1:0]  tick_cnt;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [WIDTH-1:0]   lfsr_value;

   logic               start_rise;
   logic               submit_rise;
   logic               tick_wrap;
   logic               match;
   logic               penalty;
   logic [HOLD_W-1:0]  hold_nxt;
   logic [DEC_W-1:0]   dec;
   logic [TIME_W-1:0]  time_nxt;
   logic [SCORE_W-1:0] score_nxt;
   logic [WIDTH-1:0]   new_target;

   lfsr_gen #(.WIDTH(WIDTH)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .value (lfsr_value)
   );

   assign state = st;

   // Per-cycle game events and the resulting next values while in PLAY
   always_comb begin
      start_rise  = start & ~start_q;
      submit_rise = submit & ~submit_q;
      tick_wrap   = (st == ST_PLAY) && (tick_cnt == TICK_LAST);
      match       = 1'b0;
      penalty     = 1'b0;
      hold_nxt    = '0;
      if (st == ST_PLAY) begin
         if (SUBMIT_MODE == 0) begin
            if (sw == target) begin
               if (hold_cnt == HOLD_LAST) match    = 1'b1;
               else                       hold_nxt = hold_cnt + 1'b1;
            end
         end else if (submit_rise) begin
            if (sw == target) match   = 1'b1;
            else              penalty = 1'b1;
         end
      end
      dec       = DEC_W'(tick_wrap) + (penalty ? PEN_TIME : '0);
      time_nxt  = ({1'b0, time_left} <= dec) ? '0 : time_left - TIME_W'(dec);
      score_nxt = score;
      if (match && (score != SCORE_MAX)) score_nxt = score + 1'b1;
      // Never repeat the previous target, so a held switch pattern cannot re-match
      new_target = (lfsr_value == target) ? (lfsr_value ^ WIDTH'(1)) : lfsr_value;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= ST_IDLE;
         start_q    <= 1'b1;
         submit_q   <= 1'b1;
         tick_cnt   <= '0;
         hold_cnt   <= '0;
         target     <= '0;
         time_left  <= GAME_TIME;
         score      <= '0;
         high_score <= '0;
         hit        <= 1'b0;
      end else begin
         start_q  <= start;
         submit_q <= submit;
         hit      <= 1'b0;
         case (st)
            ST_IDLE, ST_OVER: begin
               if (start_rise) begin
                  st        <= ST_PLAY;
                  score     <= '0;
                  time_left <= GAME_TIME;
                  tick_cnt  <= '0;
                  hold_cnt  <= '0;
                  target    <= lfsr_value;
               end
            end
            ST_PLAY: begin
               tick_cnt  <= tick_wrap ? '0 : tick_cnt + 1'b1;
               hold_cnt  <= hold_nxt;
               time_left <= time_nxt;
               score     <= score_nxt;
               if (match) begin
                  target <= new_target;
                  hit    <= 1'b1;
               end
               // A match on the final cycle is already folded into score_nxt
               if (time_nxt == '0) begin
                  st <= ST_OVER;
                  if (score_nxt > high_score) high_score <= score_nxt;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_binary_game_core.sv
// Directed bench for binary_game_core: one auto-match and one submit-mode instance
// share clock, reset and start; expectations flow through a scoreboard queue.
module tb_binary_game_core;

   localparam int unsigned W   = 4;
   localparam int unsigned SCW = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   sw_a, sw_b;
   logic           submit_a, submit_b;
   logic [W-1:0]   target_a, target_b;
   logic [5:0]     time_a, time_b;
   logic [SCW-1:0] score_a, score_b, high_a, high_b;
   logic [1:0]     state_a, state_b;
   logic           hit_a, hit_b;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [W-1:0] old_t;
   logic [W-1:0] t;

   always #5 clk = ~clk;

   binary_game_core #(
      .WIDTH(W), .GAME_SECONDS(3), .TICKS_PER_SEC(4), .SUBMIT_MODE(0),
      .MATCH_HOLD(2), .PENALTY_SEC(2), .SCORE_W(SCW)
   ) dut_a (
      .clk(clk), .rst(rst), .start(start), .sw(sw_a), .submit(submit_a),
      .target(target_a), .time_left(time_a), .score(score_a),
      .high_score(high_a), .state(state_a), .hit(hit_a)
   );

   binary_game_core #(
      .WIDTH(W), .GAME_SECONDS(3), .TICKS_PER_SEC(4), .SUBMIT_MODE(1),
      .MATCH_HOLD(2), .PENALTY_SEC(2), .SCORE_W(SCW)
   ) dut_b (
      .clk(clk), .rst(rst), .start(start), .sw(sw_b), .submit(submit_b),
      .target(target_b), .time_left(time_b), .score(score_b),
      .high_score(high_b), .state(state_b), .hit(hit_b)
   );

   task automatic want(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic got(input logic [31:0] obs);
      exp_t e;
      total++;
      assert (sb.size() != 0) else begin
         bad++;
         $error("FAIL scoreboard_empty: observed %0d with no expectation", obs);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sw_a = '0; sw_b = '0; submit_a = 1'b0; submit_b = 1'b0;
      cyc(2);
      want("rst_state", 0);  got(32'(state_a));
      want("rst_time", 3);   got(32'(time_a));
      want("rst_score", 0);  got(32'(score_a));
      want("rst_high", 0);   got(32'(high_a));
      want("rst_target", 0); got(32'(target_a));
      want("rst_hit", 0);    got(32'(hit_a));
      want("rst_state_b", 0); got(32'(state_b));

      // Game 1: plain timeout, 12 cycles of PLAY
      rst = 1'b0;
      cyc(1);
      start = 1'b1;
      cyc(1);
      want("g1_state", 1); got(32'(state_a));
      want("g1_time", 3);  got(32'(time_a));
      want("g1_score", 0); got(32'(score_a));
      start = 1'b0;
      sw_a = target_a ^ 4'h1;
      sw_b = target_b ^ 4'h1;
      cyc(11);
      want("g1_state_c11", 1); got(32'(state_a));
      want("g1_time_c11", 1);  got(32'(time_a));
      cyc(1);
      want("g1_over", 2);      got(32'(state_a));
      want("g1_time_end", 0);  got(32'(time_a));
      want("g1_high", 0);      got(32'(high_a));

      // Game 2: auto-match hits, a one-cycle match that must not count, score 3
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      want("g2_state", 1); got(32'(state_a));
      want("g2_time", 3);  got(32'(time_a));
      old_t = target_a;
      sw_a  = old_t;
      cyc(1);
      want("g2_hold1_hit", 0); got(32'(hit_a));
      cyc(1);
      want("g2_hit", 1);        got(32'(hit_a));
      want("g2_score1", 1);     got(32'(score_a));
      want("g2_tgt_new", 1);    got(32'(target_a != old_t));
      cyc(1);
      want("g2_hit_once", 0);   got(32'(hit_a));
      t    = target_a;
      sw_a = t;
      cyc(1);
      want("g2_short_a", 0);    got(32'(hit_a));
      sw_a = t ^ 4'h1;
      cyc(1);
      want("g2_short_b", 0);    got(32'(hit_a));
      cyc(1);
      want("g2_short_c", 0);    got(32'(hit_a));
      want("g2_short_sc", 1);   got(32'(score_a));
      repeat (2) begin
         sw_a = target_a;
         cyc(2);
         want("g2_hit_more", 1); got(32'(hit_a));
      end
      sw_a = target_a ^ 4'h1;
      cyc(2);
      want("g2_over", 2);   got(32'(state_a));
      want("g2_score", 3);  got(32'(score_a));
      want("g2_high", 3);   got(32'(high_a));
      want("g2_time", 0);   got(32'(time_a));

      // Game 3: match on the final tick in both modes
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      sw_a = target_a ^ 4'h1;
      sw_b = target_b ^ 4'h1;
      want("g3_state", 1); got(32'(state_a));
      want("g3_score", 0); got(32'(score_a));
      cyc(10);
      sw_a = target_a;
      cyc(1);
      want("g3_c11_hit", 0);   got(32'(hit_a));
      want("g3_c11_state", 1); got(32'(state_a));
      sw_b = target_b;
      submit_b = 1'b1;
      cyc(1);
      submit_b = 1'b0;
      want("g3_a_state", 2);   got(32'(state_a));
      want("g3_a_score", 1);   got(32'(score_a));
      want("g3_a_hit", 1);     got(32'(hit_a));
      want("g3_a_high", 3);    got(32'(high_a));
      want("g3_a_time", 0);    got(32'(time_a));
      want("g3_b_state", 2);   got(32'(state_b));
      want("g3_b_score", 1);   got(32'(score_b));
      want("g3_b_hit", 1);     got(32'(hit_b));
      want("g3_b_high", 1);    got(32'(high_b));

      // Game 4: wrong submits with penalty saturation; submit ignored once over
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      want("g4_b_state", 1); got(32'(state_b));
      want("g4_b_time", 3);  got(32'(time_b));
      sw_a = target_a ^ 4'h1;
      sw_b = target_b ^ 4'h1;
      submit_b = 1'b1;
      cyc(1);
      want("g4_pen1_time", 1);  got(32'(time_b));
      want("g4_pen1_state", 1); got(32'(state_b));
      want("g4_pen1_score", 0); got(32'(score_b));
      submit_b = 1'b0;
      cyc(1);
      submit_b = 1'b1;
      cyc(1);
      want("g4_pen2_time", 0);  got(32'(time_b));
      want("g4_pen2_state", 2); got(32'(state_b));
      want("g4_pen2_high", 1);  got(32'(high_b));
      submit_b = 1'b0;
      cyc(1);
      sw_b = target_b;
      submit_b = 1'b1;
      cyc(1);
      submit_b = 1'b0;
      want("g4_over_score", 0); got(32'(score_b));
      want("g4_over_time", 0);  got(32'(time_b));
      want("g4_over_hit", 0);   got(32'(hit_b));
      for (int i = 0; i < 20; i++) begin
         if (state_a == 2'b10) break;
         cyc(1);
      end
      want("g4_a_over", 2);  got(32'(state_a));
      want("g4_a_high", 3);  got(32'(high_a));
      want("g4_a_score", 0); got(32'(score_a));

      // Game 5: reset mid-game with start held high
      start = 1'b1;
      cyc(1);
      want("g5_state", 1); got(32'(state_a));
      cyc(2);
      rst = 1'b1;
      cyc(1);
      want("g5_rst_state", 0);  got(32'(state_a));
      want("g5_rst_high_a", 0); got(32'(high_a));
      want("g5_rst_high_b", 0); got(32'(high_b));
      want("g5_rst_score", 0);  got(32'(score_a));
      want("g5_rst_time", 3);   got(32'(time_a));
      want("g5_rst_target", 0); got(32'(target_a));
      rst = 1'b0;
      cyc(3);
      want("g5_held_a", 0); got(32'(state_a));
      want("g5_held_b", 0); got(32'(state_b));
      start = 1'b0;
      cyc(1);
      want("g5_low", 0); got(32'(state_a));
      start = 1'b1;
      cyc(1);
      want("g5_restart", 1);      got(32'(state_a));
      want("g5_restart_time", 3); got(32'(time_a));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/binary_game_core.md
BINARY_GAME_CORE -- requirements
Module: binary_game_core

Interface
REQ-001 Parameter WIDTH, default 8, target/switch width (2..16).
REQ-002 Parameter GAME_SECONDS, default 30, round length in seconds (1..63).
REQ-003 Parameter TICKS_PER_SEC, default 100000000, clk cycles per second (>=2).
REQ-004 Parameter SUBMIT_MODE, default 0, 0 = auto-match on held switches, 1 = explicit submit.
REQ-005 Parameter MATCH_HOLD, default 4, consecutive equal cycles for auto-match (>=1).
REQ-006 Parameter PENALTY_SEC, default 2, seconds removed on a wrong submit (SUBMIT_MODE=1 only).
REQ-007 Parameter SCORE_W, default 4, score width.
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 start  in  1  level; rising edge begins a game.
REQ-011 sw  in  WIDTH  player switches, synchronous to clk.
REQ-012 submit  in  1  level; rising edge submits guess (ignored when SUBMIT_MODE=0).
REQ-013 target  out  WIDTH  current number to match.
REQ-014 time_left  out  6  seconds remaining.
REQ-015 score  out  SCORE_W  matches this game.
REQ-016 high_score  out  SCORE_W  best score since reset.
REQ-017 state  out  2  IDLE=00, PLAY=01, OVER=10.
REQ-018 hit  out  1  one-cycle pulse per counted match.

Function
REQ-019 FSM SHALL be: IDLE -start edge-> PLAY; PLAY -time_left reaches 0-> OVER; OVER -start edge-> PLAY; start edge in PLAY ignored.
REQ-020 Entering PLAY SHALL set score=0, time_left=GAME_SECONDS, tick counter=0, target=current LFSR value, match-hold counter=0.
REQ-021 Free-running maximal-length LFSR (nonzero seed, never all-zero) SHALL advance every cycle in all states.
REQ-022 New target SHALL be LFSR[WIDTH-1:0]; if equal to the old target, the new target SHALL be that value XOR 1.
REQ-023 Tick counter SHALL count 0..TICKS_PER_SEC-1 in PLAY only; at wrap, time_left SHALL decrement by 1.
REQ-024 SUBMIT_MODE=0: hold counter increments while sw==target, clears otherwise; reaching MATCH_HOLD SHALL count a match and clear the counter.
REQ-025 SUBMIT_MODE=1: on submit rising edge in PLAY, sw==target SHALL count a match; otherwise time_left SHALL drop by PENALTY_SEC, saturating at 0.
REQ-026 Counted match SHALL, on the next edge: score+1 (saturating at 2^SCORE_W-1), new target, hit=1 for one cycle.
REQ-027 Match and final tick in the same cycle: match SHALL be counted, then state=OVER.
REQ-028 Penalty and tick in the same cycle: both SHALL apply, combined saturating at 0.
REQ-029 On entering OVER, high_score SHALL become max(high_score, score); target, score, time_left SHALL hold.
REQ-030 sw, submit and start SHALL have no effect on score/time_left outside PLAY.
REQ-031 Edge detectors on start/submit SHALL register the previous level; a level held high across reset SHALL NOT generate an edge.

Reset
REQ-032 rst SHALL force state=IDLE, target=0, time_left=GAME_SECONDS, score=0, high_score=0, hit=0, counters=0, LFSR=seed, edge registers=1.
REQ-033 rst SHALL take priority over every other event, including mid-game.

Structure
REQ-034 State encodings, LFSR seed and tap constants SHALL live in shared package binary_game_pkg.
REQ-035 LFSR SHALL be sub-module lfsr_gen (parameter WIDTH, outputs value).

Verification (WIDTH=4, GAME_SECONDS=3, TICKS_PER_SEC=4, MATCH_HOLD=2, PENALTY_SEC=2, SCORE_W=4)
REQ-036 rst then start pulse -> state=01, time_left=3, score=0; after 12 cycles state=10, time_left=0.
REQ-037 Auto mode, sw=target held 2 cycles -> hit pulses once, score=1, target changes; sw matching 1 cycle then differing -> no hit.
REQ-038 SUBMIT_MODE=1, wrong submit at time_left=3 -> time_left=1; second wrong submit -> time_left=0, state=10.
REQ-039 Match on final tick cycle -> score increments and state=10 same edge; high_score=score.
REQ-040 Games scoring 3 then 1 -> high_score stays 3; rst -> high_score=0, state=00.
REQ-041 rst asserted mid-PLAY with start held high -> state=00 and stays 00 until start falls and rises again.
